// File: rtl/tx_fifo_write_arbiter.sv
// Round-robin write-port arbiter for the transmit FIFO.
// Grants whole packets to one source at a time, caps each grant at MAX_BURST
// words, and stalls cleanly while the FIFO reports full.
module tx_fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        accept,
  output logic                      write_enable,
  output logic [DATA_W-1:0]         write_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   gidx_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;

  logic [DATA_W-1:0]  src_data [NUM_REQ];
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               active;
  logic               last_hit;
  logic               cap_hit;
  logic               dropped;
  logic               burst_end;
  logic [PTR_W-1:0]   next_ptr;

  // Split the flat data bus into one word per source.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign src_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: lowest offset from rr_ptr wins, so scan from the far end down.
  always_comb begin
    logic [PTR_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign sel_onehot = NUM_REQ'(1) << sel_idx;

  // Write path is purely combinational off the held grant; forced low during reset.
  assign active       = (state_reg == BURST) & ~rst;
  assign write_enable = active & req[gidx_reg] & ~fifo_full;
  assign accept       = write_enable ? gnt_reg : '0;
  assign write_data   = write_enable ? src_data[gidx_reg] : '0;
  assign busy         = active;
  assign gnt          = gnt_reg;

  // A burst ends on the packet's last word, on the beat cap, or when the source drops out.
  assign last_hit  = write_enable & req_last[gidx_reg];
  assign cap_hit   = write_enable & (beat_cnt_reg == BEAT_LAST);
  assign dropped   = ~req[gidx_reg];
  assign burst_end = last_hit | cap_hit | dropped;
  assign next_ptr  = PTR_W'((int'(gidx_reg) + 1) % NUM_REQ);

  // Grant FSM: IDLE picks a source, BURST holds it until one of the end conditions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      gidx_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            gnt_reg      <= sel_onehot;
            gidx_reg     <= sel_idx;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            gnt_reg      <= '0;
            rr_ptr_reg   <= next_ptr;
            beat_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else if (write_enable) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_write_arbiter.sv
// Directed bench for tx_fifo_write_arbiter: a cycle-by-cycle vector table
// plus hand-written sequences for burst cap, backpressure and async reset.
module tb_tx_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic             fifo_full;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    accept;
  logic             write_enable;
  logic [DW-1:0]    write_data;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tx_fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .fifo_full(fifo_full), .gnt(gnt), .accept(accept), .write_enable(write_enable),
    .write_data(write_data), .busy(busy)
  );

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [3:0]  lst;
    logic        full;
    logic [63:0] dat;
    logic [3:0]  egnt;
    logic [3:0]  eacc;
    logic        ewe;
    logic [15:0] ewd;
    logic        ebusy;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // dat packs four 16-bit source words, source i at bits [i*16 +: 16].
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                       input logic full, input logic [63:0] dat);
    rst       = r;
    req       = rq;
    req_last  = lst;
    fifo_full = full;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(dat[i*16 +: 16]);
  endtask

  // Called just after a rising edge; checks mid-cycle, returns just after the next edge.
  task automatic cyc(input string tag, input logic r, input logic [3:0] rq, input logic [3:0] lst,
                     input logic full, input logic [63:0] dat,
                     input logic [3:0] egnt, input logic [3:0] eacc, input logic ewe,
                     input logic [15:0] ewd, input logic ebusy);
    drive(r, rq, lst, full, dat);
    @(negedge clk);
    chk({tag, " gnt"},    128'(gnt),          128'(egnt));
    chk({tag, " accept"}, 128'(accept),       128'(eacc));
    chk({tag, " we"},     128'(write_enable), 128'(ewe));
    chk({tag, " wdata"},  write_data,         128'(ewd));
    chk({tag, " busy"},   128'(busy),         128'(ebusy));
    $display("%s: req=%b gnt=%b acc=%b we=%b wd=%0h busy=%b", tag, req, gnt, accept,
             write_enable, write_data, busy);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] lst, input logic full,
                     input logic [63:0] dat, input logic [3:0] egnt, input logic [3:0] eacc,
                     input logic ewe, input logic [15:0] ewd, input logic ebusy);
    vec_t v;
    v.r = r; v.rq = rq; v.lst = lst; v.full = full; v.dat = dat;
    v.egnt = egnt; v.eacc = eacc; v.ewe = ewe; v.ewd = ewd; v.ebusy = ebusy;
    vt.push_back(v);
  endtask

  localparam logic [63:0] D3 = 64'h0013_0012_0011_0010;
  localparam logic [63:0] Z  = 64'h0;

  initial begin
    drive(1'b1, 4'b0, 4'b0, 1'b0, Z);
    @(posedge clk);
    #1;

    // Single 3-word packet from src0
    add(1, 4'h0, 4'h0, 0, Z,     4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'h1, 4'h0, 0, 64'h1, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'h1, 4'h0, 0, 64'h1, 4'h1, 4'h1, 1, 16'h1, 1);
    add(0, 4'h1, 4'h0, 0, 64'h2, 4'h1, 4'h1, 1, 16'h2, 1);
    add(0, 4'h1, 4'h1, 0, 64'h3, 4'h1, 4'h1, 1, 16'h3, 1);
    add(0, 4'h0, 4'h0, 0, Z,     4'h0, 4'h0, 0, 16'h0, 0);
    // Round-robin over four 1-word packets
    add(1, 4'h0, 4'h0, 0, Z,  4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h1, 4'h1, 1, 16'h10, 1);
    add(0, 4'hF, 4'hF, 0, D3, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h2, 4'h2, 1, 16'h11, 1);
    add(0, 4'hF, 4'hF, 0, D3, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h4, 4'h4, 1, 16'h12, 1);
    add(0, 4'hF, 4'hF, 0, D3, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h8, 4'h8, 1, 16'h13, 1);
    add(0, 4'hF, 4'hF, 0, D3, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'hF, 4'hF, 0, D3, 4'h1, 4'h1, 1, 16'h10, 1);
    add(0, 4'h0, 4'h0, 0, Z,  4'h0, 4'h0, 0, 16'h0, 0);
    // Abandon: src0 drops after 2 words, src1 (also requesting) ignored until then
    add(1, 4'h0, 4'h0, 0, Z,                     4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'h3, 4'h0, 0, 64'h0000_0000_0031_0021, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'h3, 4'h0, 0, 64'h0000_0000_0031_0021, 4'h1, 4'h1, 1, 16'h21, 1);
    add(0, 4'h3, 4'h0, 0, 64'h0000_0000_0031_0022, 4'h1, 4'h1, 1, 16'h22, 1);
    add(0, 4'h2, 4'h0, 0, 64'h0000_0000_0031_0022, 4'h1, 4'h0, 0, 16'h0, 1);
    add(0, 4'h3, 4'h0, 0, 64'h0000_0000_0031_0022, 4'h0, 4'h0, 0, 16'h0, 0);
    add(0, 4'h3, 4'h2, 0, 64'h0000_0000_0031_0022, 4'h2, 4'h2, 1, 16'h31, 1);
    add(0, 4'h0, 4'h0, 0, Z,                     4'h0, 4'h0, 0, 16'h0, 0);

    foreach (vt[i]) begin
      cyc($sformatf("vec%0d", i), vt[i].r, vt[i].rq, vt[i].lst, vt[i].full, vt[i].dat,
          vt[i].egnt, vt[i].eacc, vt[i].ewe, vt[i].ewd, vt[i].ebusy);
    end

    // Burst cap: src2 12-word packet with src3 waiting
    cyc("cap rst", 1, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("cap idle", 0, 4'hC, 4'h0, 0, {16'h0050, 16'h0041, 32'h0}, 4'h0, 4'h0, 0, 16'h0, 0);
    for (int w = 1; w <= 8; w++)
      cyc($sformatf("cap w%0d", w), 0, 4'hC, 4'h0, 0, {16'h0050, 16'(64 + w), 32'h0},
          4'h4, 4'h4, 1, 16'(64 + w), 1);
    cyc("cap gap1", 0, 4'hC, 4'h0, 0, {16'h0050, 16'h0049, 32'h0}, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("cap src3", 0, 4'hC, 4'h8, 0, {16'h0050, 16'h0049, 32'h0}, 4'h8, 4'h8, 1, 16'h50, 1);
    cyc("cap gap2", 0, 4'h4, 4'h0, 0, {16'h0000, 16'h0049, 32'h0}, 4'h0, 4'h0, 0, 16'h0, 0);
    for (int w = 9; w <= 12; w++)
      cyc($sformatf("cap w%0d", w), 0, 4'h4, (w == 12) ? 4'h4 : 4'h0, 0,
          {16'h0000, 16'(64 + w), 32'h0}, 4'h4, 4'h4, 1, 16'(64 + w), 1);
    cyc("cap end", 0, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);

    // Backpressure: src1 stalled 4 clocks after word 2
    cyc("bp rst", 1, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("bp idle", 0, 4'h2, 4'h0, 0, 64'h0061_0000, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("bp w1", 0, 4'h2, 4'h0, 0, 64'h0061_0000, 4'h2, 4'h2, 1, 16'h61, 1);
    cyc("bp w2", 0, 4'h2, 4'h0, 0, 64'h0062_0000, 4'h2, 4'h2, 1, 16'h62, 1);
    for (int s = 0; s < 4; s++)
      cyc($sformatf("bp stall%0d", s), 0, 4'h2, 4'h0, 1, 64'h0063_0000, 4'h2, 4'h0, 0, 16'h0, 1);
    cyc("bp w3", 0, 4'h2, 4'h0, 0, 64'h0063_0000, 4'h2, 4'h2, 1, 16'h63, 1);
    cyc("bp w4", 0, 4'h2, 4'h2, 0, 64'h0064_0000, 4'h2, 4'h2, 1, 16'h64, 1);
    cyc("bp end", 0, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);

    // Asynchronous reset in the middle of a burst
    cyc("ar rst", 1, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("ar idle", 0, 4'h1, 4'h0, 0, 64'h00A1, 4'h0, 4'h0, 0, 16'h0, 0);
    drive(1'b0, 4'h1, 4'h0, 1'b0, 64'h00A2);
    @(negedge clk);
    chk("ar pre we", 128'(write_enable), 128'(1'b1));
    chk("ar pre wdata", write_data, 128'h00A2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar mid gnt", 128'(gnt), 128'(4'h0));
    chk("ar mid we", 128'(write_enable), 128'(1'b0));
    chk("ar mid busy", 128'(busy), 128'(1'b0));
    chk("ar mid accept", 128'(accept), 128'(4'h0));
    chk("ar mid wdata", write_data, 128'h0);
    $display("ar mid: gnt=%b we=%b busy=%b", gnt, write_enable, busy);
    @(posedge clk);
    #1;
    cyc("ar rel", 0, 4'h1, 4'h0, 0, 64'h00B1, 4'h0, 4'h0, 0, 16'h0, 0);
    cyc("ar regnt", 0, 4'h1, 4'h1, 0, 64'h00B1, 4'h1, 4'h1, 1, 16'hB1, 1);
    cyc("ar end", 0, 4'h0, 4'h0, 0, Z, 4'h0, 4'h0, 0, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
